// File: rtl/sub_seq_arbiter_if.sv
// Request/response bundle between the requesting engines and the shared subtract scheduler.
interface sub_seq_arbiter_if #(
    parameter int unsigned NREQ   = 2,
    parameter int unsigned NBYTES = 4
);
    localparam int unsigned W   = 8 * NBYTES;
    localparam int unsigned IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [W-1:0]      rsp_diff;
    logic              rsp_borrow;
    logic              busy;

    // Requesting side: drives requests and consumes the response.
    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_diff, rsp_borrow, busy
    );

    // Scheduler side.
    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_diff, rsp_borrow, busy
    );
endinterface

// File: rtl/sub_seq_arbiter.sv
// Round-robin scheduler sharing one 8-bit subtract slice among NREQ requesters,
// processing each operand pair LSB byte first with a chained carry.
module sub_seq_arbiter #(
    parameter int unsigned NREQ   = 2,
    parameter int unsigned NBYTES = 4
) (
    input  logic             clk,
    input  logic             rst,
    sub_seq_arbiter_if.slave bus
);
    localparam int unsigned W   = 8 * NBYTES;
    localparam int unsigned IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned CW  = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state;
    state_t          state_nxt;
    logic [IDW-1:0]  last_grant;
    logic [IDW-1:0]  grant_c;
    logic [IDW-1:0]  id_q;
    logic [CW-1:0]   cnt;
    logic            carry;
    logic [W-1:0]    opa;
    logic [W-1:0]    opb;
    logic [W-1:0]    diff_q;
    logic            borrow_q;
    logic            valid_q;
    logic            busy_q;
    logic [NREQ-1:0] ready_c;
    logic            accept_c;
    logic            last_byte_c;
    logic [7:0]      a_byte_c;
    logic [7:0]      b_inv_c;
    logic [8:0]      sum_c;

    // First valid requester after 'last', wrapping; nearest candidate is evaluated last so it wins.
    function automatic logic [IDW-1:0] rr_pick(input logic [NREQ-1:0] v, input logic [IDW-1:0] last);
        logic [IDW-1:0] pick;
        int unsigned    idx;
        pick = last;
        for (int unsigned k = NREQ; k >= 1; k--) begin
            idx = (32'(last) + k) % NREQ;
            if (v[IDW'(idx)]) pick = IDW'(idx);
        end
        return pick;
    endfunction

    // Round-robin grant candidate.
    always_comb begin
        grant_c = rr_pick(bus.req_valid, last_grant);
    end

    // One byte of the subtract slice: A + ~B + carry.
    always_comb begin
        a_byte_c    = opa[32'(cnt) * 8 +: 8];
        b_inv_c     = ~opb[32'(cnt) * 8 +: 8];
        sum_c       = 9'(a_byte_c) + 9'(b_inv_c) + 9'(carry);
        last_byte_c = (cnt == CW'(NBYTES - 1));
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next state and the combinational accept strobe.
    always_comb begin
        state_nxt = state;
        ready_c   = '0;
        case (state)
            IDLE: begin
                if (!rst && (|bus.req_valid)) begin
                    ready_c[grant_c] = 1'b1;
                    state_nxt        = RUN;
                end
            end
            RUN: begin
                if (last_byte_c) state_nxt = DONE;
            end
            DONE: begin
                if (bus.rsp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign accept_c = |ready_c;

    // Operand capture, byte-serial result build-up and response registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            carry      <= 1'b1;
            last_grant <= IDW'(NREQ - 1);
            opa        <= '0;
            opb        <= '0;
            id_q       <= '0;
            diff_q     <= '0;
            borrow_q   <= 1'b0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept_c) begin
                        opa        <= bus.req_a[32'(grant_c) * W +: W];
                        opb        <= bus.req_b[32'(grant_c) * W +: W];
                        id_q       <= grant_c;
                        last_grant <= grant_c;
                        cnt        <= '0;
                        carry      <= 1'b1;
                        busy_q     <= 1'b1;
                    end
                end
                RUN: begin
                    diff_q[32'(cnt) * 8 +: 8] <= sum_c[7:0];
                    carry                     <= sum_c[8];
                    cnt                       <= cnt + CW'(1);
                    if (last_byte_c) begin
                        cnt      <= '0;
                        borrow_q <= ~sum_c[8];
                        valid_q  <= 1'b1;
                    end
                end
                DONE: begin
                    if (bus.rsp_ready) begin
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.req_ready  = ready_c;
    assign bus.rsp_valid  = valid_q;
    assign bus.rsp_id     = id_q;
    assign bus.rsp_diff   = diff_q;
    assign bus.rsp_borrow = borrow_q;
    assign bus.busy       = busy_q;

endmodule

// File: tb/tb_sub_seq_arbiter.sv
// Bench for sub_seq_arbiter: transaction-level reference model checked every cycle,
// directed literal cases, then randomized requests, backpressure and resets.
module tb_sub_seq_arbiter;
    localparam int unsigned NREQ   = 2;
    localparam int unsigned NBYTES = 4;
    localparam int unsigned W      = 8 * NBYTES;
    localparam int unsigned IDW    = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic clk = 1'b0;
    logic rst = 1'b1;

    sub_seq_arbiter_if #(.NREQ(NREQ), .NBYTES(NBYTES)) bus ();
    sub_seq_arbiter #(.NREQ(NREQ), .NBYTES(NBYTES)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    int checks  = 0;
    int errors  = 0;
    int cyc     = 0;
    int rsp_cnt = 0;
    bit chk_en  = 1'b0;

    // Reference model: idle / remaining run cycles / response pending.
    bit              m_idle  = 1'b1;
    bit              m_resp  = 1'b0;
    bit              m_clean = 1'b1;
    int              m_run   = 0;
    int              m_last  = NREQ - 1;
    int              m_id    = 0;
    logic [W-1:0]    m_a     = '0;
    logic [W-1:0]    m_b     = '0;
    logic [NREQ-1:0] acc_flag = '0;
    int              acc_cyc[$];
    int              acc_id[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h cyc=%0d", name, act, exp, cyc);
        end
    endtask

    function automatic int rr(input logic [NREQ-1:0] v, input int last);
        int j;
        for (int k = 1; k <= int'(NREQ); k++) begin
            j = (last + k) % int'(NREQ);
            if (v[IDW'(j)]) return j;
        end
        return -1;
    endfunction

    // Compare DUT against the model, then advance the model over the coming edge.
    always @(negedge clk) begin : cmp
        logic [NREQ-1:0] exp_ready;
        logic [W-1:0]    exp_diff;
        logic            exp_borrow;
        int              g;
        exp_ready = '0;
        g = rr(bus.req_valid, m_last);
        if (!rst && m_idle && g >= 0) exp_ready[IDW'(g)] = 1'b1;
        exp_diff   = m_clean ? '0 : W'(m_a - m_b);
        exp_borrow = m_clean ? 1'b0 : (m_a < m_b);
        if (chk_en) begin
            chk("req_ready", 64'(bus.req_ready), 64'(exp_ready));
            chk("rsp_valid", 64'(bus.rsp_valid), 64'(m_resp));
            chk("busy", 64'(bus.busy), 64'(!m_idle));
            chk("rsp_id", 64'(bus.rsp_id), 64'(m_id));
            if (m_resp || m_clean) begin
                chk("rsp_diff", 64'(bus.rsp_diff), 64'(exp_diff));
                chk("rsp_borrow", 64'(bus.rsp_borrow), 64'(exp_borrow));
            end
        end
        if (bus.rsp_valid === 1'b1) rsp_cnt++;
        acc_flag = '0;
        if (rst) begin
            m_idle = 1'b1; m_resp = 1'b0; m_clean = 1'b1; m_run = 0;
            m_last = NREQ - 1; m_id = 0;
        end else if (m_idle) begin
            if (exp_ready != '0) begin
                acc_flag = exp_ready;
                acc_cyc.push_back(cyc);
                acc_id.push_back(g);
                m_a = bus.req_a[g * W +: W];
                m_b = bus.req_b[g * W +: W];
                m_id = g; m_last = g; m_run = NBYTES;
                m_idle = 1'b0; m_clean = 1'b0;
            end
        end else if (m_run > 0) begin
            m_run--;
            if (m_run == 0) m_resp = 1'b1;
        end else if (bus.rsp_ready) begin
            m_resp = 1'b0; m_idle = 1'b1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int id, input logic v, input logic [W-1:0] a, input logic [W-1:0] b);
        bus.req_valid[IDW'(id)] = v;
        bus.req_a[id * W +: W]  = a;
        bus.req_b[id * W +: W]  = b;
    endtask

    task automatic wait_acc(input int id, output int t);
        int n;
        n = 0;
        tick();
        while (!acc_flag[IDW'(id)] && n < 30) begin
            tick();
            n++;
        end
        chk("accept_timeout", 64'(acc_flag[IDW'(id)]), 64'd1);
        t = (acc_cyc.size() > 0) ? acc_cyc[$] : -1;
    endtask

    task automatic wait_rsp();
        int n;
        n = 0;
        while (bus.rsp_valid !== 1'b1 && n < 30) begin
            tick();
            n++;
        end
        chk("rsp_timeout", 64'(bus.rsp_valid), 64'd1);
    endtask

    task automatic op(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [W-1:0] ed, input logic eb, input int lat);
        int t;
        drive(id, 1'b1, a, b);
        #1;
        chk("req_ready_lit", 64'(bus.req_ready), 64'd1 << id);
        wait_acc(id, t);
        drive(id, 1'b0, a, b);
        wait_rsp();
        if (lat > 0) chk("latency", 64'(cyc - t), 64'(lat));
        chk("rsp_id_lit", 64'(bus.rsp_id), 64'(id));
        chk("rsp_diff_lit", 64'(bus.rsp_diff), 64'(ed));
        chk("rsp_borrow_lit", 64'(bus.rsp_borrow), 64'(eb));
        tick();
    endtask

    function automatic logic [W-1:0] rnd();
        case ($urandom_range(0, 3))
            0:       return W'($urandom_range(0, 3));
            1:       return {W{1'b1}};
            default: return W'({$urandom(), $urandom()});
        endcase
    endfunction

    initial begin
        int t, r, rc, n0, n;
        logic [W-1:0] snap_d;
        logic [W-1:0] ra;
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 1'b1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b1;
        tick();
        chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
        chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("rst_rsp_id", 64'(bus.rsp_id), 64'd0);
        chk("rst_rsp_diff", 64'(bus.rsp_diff), 64'd0);
        chk("rst_rsp_borrow", 64'(bus.rsp_borrow), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        rst = 1'b0;

        // Directed arithmetic cases.
        op(0, 32'h1234_5678, 32'h0000_0001, 32'h1234_5677, 1'b0, 5);
        op(1, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b1, 5);
        op(0, 32'h0000_0100, 32'h0000_0001, 32'h0000_00FF, 1'b0, 5);
        op(1, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 32'h0000_0000, 1'b0, 5);

        // Backpressure in DONE.
        bus.rsp_ready = 1'b0;
        drive(0, 1'b1, 32'h0000_00FF, 32'h0000_0100);
        wait_acc(0, t);
        drive(0, 1'b0, 32'h0000_00FF, 32'h0000_0100);
        drive(1, 1'b1, 32'h0000_0005, 32'h0000_0003);
        wait_rsp();
        snap_d = bus.rsp_diff;
        chk("bp_diff_lit", 64'(snap_d), 64'hFFFF_FFFF);
        chk("bp_borrow_lit", 64'(bus.rsp_borrow), 64'd1);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("bp_valid_hold", 64'(bus.rsp_valid), 64'd1);
            chk("bp_diff_hold", 64'(bus.rsp_diff), 64'(snap_d));
            chk("bp_id_hold", 64'(bus.rsp_id), 64'd0);
            chk("bp_ready_low", 64'(bus.req_ready), 64'd0);
        end
        bus.rsp_ready = 1'b1;
        r = cyc;
        tick();
        tick();
        chk("bp_next_accept_cyc", 64'(acc_cyc[$]), 64'(r + 1));
        chk("bp_next_accept_id", 64'(acc_id[$]), 64'd1);
        drive(1, 1'b0, 32'h0000_0005, 32'h0000_0003);
        wait_rsp();
        chk("bp2_diff_lit", 64'(bus.rsp_diff), 64'd2);
        tick();

        // Reset in the middle of RUN, then contention.
        drive(0, 1'b1, 32'hDEAD_BEEF, 32'h1111_1111);
        wait_acc(0, t);
        drive(0, 1'b0, 32'hDEAD_BEEF, 32'h1111_1111);
        tick();
        tick();
        rst = 1'b1;
        rc = rsp_cnt;
        tick();
        chk("mr_no_rsp", 64'(rsp_cnt), 64'(rc));
        chk("mr_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("mr_busy", 64'(bus.busy), 64'd0);
        chk("mr_rsp_id", 64'(bus.rsp_id), 64'd0);
        chk("mr_rsp_diff", 64'(bus.rsp_diff), 64'd0);
        chk("mr_rsp_borrow", 64'(bus.rsp_borrow), 64'd0);
        chk("mr_req_ready", 64'(bus.req_ready), 64'd0);
        rst = 1'b0;
        drive(1, 1'b1, 32'h0000_0010, 32'h0000_0020);
        drive(0, 1'b1, 32'h0000_0030, 32'h0000_0008);
        n0 = acc_id.size();
        n = 0;
        while (acc_id.size() < n0 + 4 && n < 60) begin
            tick();
            n++;
        end
        chk("cont_count", 64'(acc_id.size() >= n0 + 4), 64'd1);
        if (acc_id.size() >= n0 + 4) begin
            for (int k = 0; k < 4; k++) chk("cont_order", 64'(acc_id[n0 + k]), 64'(k % 2));
            for (int k = 0; k < 3; k++) chk("cont_spacing", 64'(acc_cyc[n0 + k + 1] - acc_cyc[n0 + k]), 64'd6);
        end
        drive(0, 1'b0, '0, '0);
        drive(1, 1'b0, '0, '0);
        n = 0;
        while (bus.busy !== 1'b0 && n < 30) begin
            tick();
            n++;
        end
        chk("cont_drain", 64'(bus.busy), 64'd0);

        // Randomized traffic with backpressure and occasional resets.
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 199) == 0);
            bus.rsp_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < int'(NREQ); i++) begin
                if (acc_flag[IDW'(i)] || !bus.req_valid[IDW'(i)]) begin
                    ra = rnd();
                    if ($urandom_range(0, 1) == 1)
                        drive(i, 1'b1, ra, ($urandom_range(0, 4) == 0) ? ra : rnd());
                    else
                        drive(i, 1'b0, ra, rnd());
                end else if ($urandom_range(0, 19) == 0) begin
                    bus.req_valid[IDW'(i)] = 1'b0;
                end
            end
            tick();
        end
        rst = 1'b0;
        bus.rsp_ready = 1'b1;
        bus.req_valid = '0;
        n = 0;
        while (bus.busy !== 1'b0 && n < 30) begin
            tick();
            n++;
        end
        chk("final_drain", 64'(bus.busy), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
